// File: rtl/nurn_cfg_mem_prog.sv
// Per-core neuron config store: registered read ports A/B/C, field-granular config writes, post-reset clear sweep.
// Reads 1 cycle; C writes 1/cycle; A/B writes are 3-cycle RMW with cfg_ready_o low in RMW_RD/RMW_WR.
module nurn_cfg_mem_prog #(
  parameter int NUM_NURNS          = 256,
  parameter int NUM_AXONS          = 256,
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8,
  parameter int STDP_WIN_BIT_WIDTH = 8,
  parameter int AER_BIT_WIDTH      = 32,
  parameter int CFG_DATA_WIDTH     = 32,
  parameter bit INIT_CLEAR         = 1'b1
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]                    Addr_Config_A_i,
  input  logic                                             rdEn_Config_A_i,
  output logic [STDP_WIN_BIT_WIDTH-1:0]                    LTP_Win_o,
  output logic [STDP_WIN_BIT_WIDTH-1:0]                    LTD_Win_o,
  output logic [DSIZE-1:0]                                 LTP_LrnRt_o,
  output logic [DSIZE-1:0]                                 LTD_LrnRt_o,
  output logic                                             biasLrnMode_o,
  input  logic [NURN_CNT_BIT_WIDTH-1:0]                    Addr_Config_B_i,
  input  logic                                             rdEn_Config_B_i,
  output logic                                             NurnType_o,
  output logic                                             RandTh_o,
  output logic [DSIZE-1:0]                                 Th_Mask_o,
  output logic [DSIZE-1:0]                                 RstPot_o,
  output logic [AER_BIT_WIDTH-1:0]                         SpikeAER_o,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_i,
  input  logic                                             rdEn_Config_C_i,
  output logic                                             axonLrnMode_o,
  input  logic                                             cfg_valid_i,
  output logic                                             cfg_ready_o,
  input  logic [1:0]                                       cfg_sel_i,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] cfg_addr_i,
  input  logic [2:0]                                       cfg_field_i,
  input  logic [CFG_DATA_WIDTH-1:0]                        cfg_data_i,
  output logic                                             init_done_o,
  output logic                                             cfg_err_o
);
  localparam int NW      = NURN_CNT_BIT_WIDTH;
  localparam int AW      = AXON_CNT_BIT_WIDTH;
  localparam int C_DEPTH = NUM_NURNS * NUM_AXONS;
  localparam int NI      = (NUM_NURNS > 1) ? $clog2(NUM_NURNS) : 1;
  localparam int CI      = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam logic [CI-1:0] C_LAST = CI'(C_DEPTH - 1);

  typedef struct packed {
    logic                          bias;
    logic [DSIZE-1:0]              ltd_lr;
    logic [DSIZE-1:0]              ltp_lr;
    logic [STDP_WIN_BIT_WIDTH-1:0] ltd_win;
    logic [STDP_WIN_BIT_WIDTH-1:0] ltp_win;
  } a_word_t;

  typedef struct packed {
    logic [AER_BIT_WIDTH-1:0] spike_aer;
    logic [DSIZE-1:0]         rst_pot;
    logic [DSIZE-1:0]         th_mask;
    logic                     rand_th;
    logic                     nurn_type;
  } b_word_t;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RMW_RD, S_RMW_WR} state_t;

  function automatic a_word_t a_merge(input a_word_t w, input logic [2:0] f,
                                      input logic [CFG_DATA_WIDTH-1:0] d);
    a_merge = w;
    case (f)
      3'd0: a_merge.ltp_win = d[STDP_WIN_BIT_WIDTH-1:0];
      3'd1: a_merge.ltd_win = d[STDP_WIN_BIT_WIDTH-1:0];
      3'd2: a_merge.ltp_lr  = d[DSIZE-1:0];
      3'd3: a_merge.ltd_lr  = d[DSIZE-1:0];
      3'd4: a_merge.bias    = d[0];
      default: ;
    endcase
  endfunction

  function automatic b_word_t b_merge(input b_word_t w, input logic [2:0] f,
                                      input logic [CFG_DATA_WIDTH-1:0] d);
    b_merge = w;
    case (f)
      3'd0: b_merge.nurn_type = d[0];
      3'd1: b_merge.rand_th   = d[0];
      3'd2: b_merge.th_mask   = d[DSIZE-1:0];
      3'd3: b_merge.rst_pot   = d[DSIZE-1:0];
      3'd4: b_merge.spike_aer = d[AER_BIT_WIDTH-1:0];
      default: ;
    endcase
  endfunction

  function automatic logic [CI-1:0] c_lin(input logic [NW-1:0] n, input logic [AW-1:0] a);
    return CI'(int'(n) * NUM_AXONS + int'(a));
  endfunction

  a_word_t a_mem [NUM_NURNS];
  b_word_t b_mem [NUM_NURNS];
  logic    c_mem [C_DEPTH];

  state_t                    state_q, state_d;
  logic [CI-1:0]             idx_q, idx_d;
  logic [1:0]                sel_q, sel_d;
  logic [NW-1:0]             nurn_q, nurn_d;
  logic [2:0]                field_q, field_d;
  logic [CFG_DATA_WIDTH-1:0] data_q, data_d;
  a_word_t                   a_old_q, a_old_d, a_rd_q, a_rd_d;
  b_word_t                   b_old_q, b_old_d, b_rd_q, b_rd_d;
  logic                      c_rd_q, c_rd_d;
  logic                      ready_q, ready_d, init_done_q, init_done_d, err_q, err_d;

  logic [NW-1:0] cfg_nurn, rd_nurn;
  logic [AW-1:0] cfg_axon, rd_axon;
  logic          accept, bad, c_wr, c_rd_ok;
  logic [CI-1:0] c_waddr, c_raddr;
  a_word_t       a_new, a_wd;
  b_word_t       b_new, b_wd;
  logic          a_we, b_we, c_we, c_wd;
  logic [NI-1:0] ab_wa;
  logic [CI-1:0] c_wa;
  logic          unused_data;

  assign cfg_nurn = cfg_addr_i[NW+AW-1:AW];
  assign cfg_axon = cfg_addr_i[AW-1:0];
  assign rd_nurn  = Addr_Config_C_i[NW+AW-1:AW];
  assign rd_axon  = Addr_Config_C_i[AW-1:0];
  assign accept   = cfg_valid_i & ready_q;
  assign bad      = (cfg_sel_i == 2'd3) || (cfg_sel_i != 2'd2 && cfg_field_i > 3'd4) ||
                    (int'(cfg_nurn) >= NUM_NURNS) ||
                    (cfg_sel_i == 2'd2 && int'(cfg_axon) >= NUM_AXONS);
  assign c_wr     = accept & ~bad & (cfg_sel_i == 2'd2);
  assign c_waddr  = c_lin(cfg_nurn, cfg_axon);
  assign c_raddr  = c_lin(rd_nurn, rd_axon);
  assign c_rd_ok  = (int'(rd_nurn) < NUM_NURNS) && (int'(rd_axon) < NUM_AXONS);
  assign a_new    = a_merge(a_old_q, field_q, data_q);
  assign b_new    = b_merge(b_old_q, field_q, data_q);
  assign unused_data = ^data_q;

  // Single write port per table: clear sweep, C accept-cycle write, or RMW_WR commit.
  always_comb begin
    a_we  = 1'b0;
    b_we  = 1'b0;
    c_we  = 1'b0;
    ab_wa = nurn_q[NI-1:0];
    c_wa  = c_waddr;
    a_wd  = a_new;
    b_wd  = b_new;
    c_wd  = cfg_data_i[0];
    if (state_q == S_INIT) begin
      c_we = 1'b1;
      c_wa = idx_q;
      c_wd = 1'b0;
      a_wd = '0;
      b_wd = '0;
      ab_wa = idx_q[NI-1:0];
      if (int'(idx_q) < NUM_NURNS) begin
        a_we = 1'b1;
        b_we = 1'b1;
      end
    end else if (state_q == S_RMW_WR) begin
      a_we = (sel_q == 2'd0);
      b_we = (sel_q == 2'd1);
    end
    if (c_wr) c_we = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (a_we) a_mem[ab_wa] <= a_wd;
      if (b_we) b_mem[ab_wa] <= b_wd;
      if (c_we) c_mem[c_wa]  <= c_wd;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    nurn_d      = nurn_q;
    field_d     = field_q;
    data_d      = data_q;
    a_old_d     = a_old_q;
    b_old_d     = b_old_q;
    err_d       = err_q;
    init_done_d = init_done_q | ~INIT_CLEAR;
    case (state_q)
      S_INIT: begin
        idx_d = idx_q + CI'(1);
        if (idx_q == C_LAST) begin
          state_d     = S_IDLE;
          idx_d       = '0;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (bad) begin
            err_d = 1'b1;
          end else if (cfg_sel_i != 2'd2) begin
            state_d = S_RMW_RD;
            sel_d   = cfg_sel_i;
            nurn_d  = cfg_nurn;
            field_d = cfg_field_i;
            data_d  = cfg_data_i;
          end
        end
      end
      S_RMW_RD: begin
        a_old_d = a_mem[nurn_q[NI-1:0]];
        b_old_d = b_mem[nurn_q[NI-1:0]];
        state_d = S_RMW_WR;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Read ports: write-first bypass against the word being committed this cycle.
  always_comb begin
    a_rd_d = a_rd_q;
    b_rd_d = b_rd_q;
    c_rd_d = c_rd_q;
    if (state_q != S_INIT) begin
      if (rdEn_Config_A_i) begin
        if (int'(Addr_Config_A_i) >= NUM_NURNS) a_rd_d = '0;
        else if (state_q == S_RMW_WR && sel_q == 2'd0 && nurn_q == Addr_Config_A_i) a_rd_d = a_new;
        else a_rd_d = a_mem[Addr_Config_A_i[NI-1:0]];
      end
      if (rdEn_Config_B_i) begin
        if (int'(Addr_Config_B_i) >= NUM_NURNS) b_rd_d = '0;
        else if (state_q == S_RMW_WR && sel_q == 2'd1 && nurn_q == Addr_Config_B_i) b_rd_d = b_new;
        else b_rd_d = b_mem[Addr_Config_B_i[NI-1:0]];
      end
      if (rdEn_Config_C_i) begin
        if (!c_rd_ok) c_rd_d = 1'b0;
        else if (c_wr && c_waddr == c_raddr) c_rd_d = cfg_data_i[0];
        else c_rd_d = c_mem[c_raddr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT_CLEAR ? S_INIT : S_IDLE;
      idx_q       <= '0;
      sel_q       <= '0;
      nurn_q      <= '0;
      field_q     <= '0;
      data_q      <= '0;
      a_old_q     <= '0;
      b_old_q     <= '0;
      a_rd_q      <= '0;
      b_rd_q      <= '0;
      c_rd_q      <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      nurn_q      <= nurn_d;
      field_q     <= field_d;
      data_q      <= data_d;
      a_old_q     <= a_old_d;
      b_old_q     <= b_old_d;
      a_rd_q      <= a_rd_d;
      b_rd_q      <= b_rd_d;
      c_rd_q      <= c_rd_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign LTP_Win_o     = a_rd_q.ltp_win;
  assign LTD_Win_o     = a_rd_q.ltd_win;
  assign LTP_LrnRt_o   = a_rd_q.ltp_lr;
  assign LTD_LrnRt_o   = a_rd_q.ltd_lr;
  assign biasLrnMode_o = a_rd_q.bias;
  assign NurnType_o    = b_rd_q.nurn_type;
  assign RandTh_o      = b_rd_q.rand_th;
  assign Th_Mask_o     = b_rd_q.th_mask;
  assign RstPot_o      = b_rd_q.rst_pot;
  assign SpikeAER_o    = b_rd_q.spike_aer;
  assign axonLrnMode_o = c_rd_q;
  assign cfg_ready_o   = ready_q;
  assign init_done_o   = init_done_q;
  assign cfg_err_o     = err_q;
endmodule

// File: tb/tb_nurn_cfg_mem_prog.sv
// Directed bench for nurn_cfg_mem_prog with a 4-neuron x 4-axon core.
module tb_nurn_cfg_mem_prog;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr_a = '0, addr_b = '0;
  logic [15:0] addr_c = '0, cfg_addr = '0;
  logic        rd_a = 1'b0, rd_b = 1'b0, rd_c = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [2:0]  cfg_field = '0;
  logic [31:0] cfg_data = '0;
  logic [7:0]  ltp_win, ltd_win;
  logic [15:0] ltp_lr, ltd_lr, th_mask, rst_pot;
  logic [31:0] spike_aer;
  logic        bias, nurn_type, rand_th, axon_lm, cfg_ready, init_done, cfg_err;
  logic [48:0] a_all;
  logic [65:0] b_all;
  int          checks = 0;
  int          errors = 0;

  assign a_all = {bias, ltd_lr, ltp_lr, ltd_win, ltp_win};
  assign b_all = {spike_aer, rst_pot, th_mask, rand_th, nurn_type};

  always #5 clk = ~clk;

  nurn_cfg_mem_prog #(.NUM_NURNS(4), .NUM_AXONS(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .Addr_Config_A_i(addr_a), .rdEn_Config_A_i(rd_a),
    .LTP_Win_o(ltp_win), .LTD_Win_o(ltd_win), .LTP_LrnRt_o(ltp_lr), .LTD_LrnRt_o(ltd_lr),
    .biasLrnMode_o(bias),
    .Addr_Config_B_i(addr_b), .rdEn_Config_B_i(rd_b),
    .NurnType_o(nurn_type), .RandTh_o(rand_th), .Th_Mask_o(th_mask), .RstPot_o(rst_pot),
    .SpikeAER_o(spike_aer),
    .Addr_Config_C_i(addr_c), .rdEn_Config_C_i(rd_c), .axonLrnMode_o(axon_lm),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_sel_i(cfg_sel),
    .cfg_addr_i(cfg_addr), .cfg_field_i(cfg_field), .cfg_data_i(cfg_data),
    .init_done_o(init_done), .cfg_err_o(cfg_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rd(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    addr_a = a; addr_b = b; addr_c = c;
    rd_a = 1'b1; rd_b = 1'b1; rd_c = 1'b1;
    tick;
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] addr,
                           input logic [2:0] field, input logic [31:0] data);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin tick; n++; end
    cfg_valid = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_field = field; cfg_data = data;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(output int low);
    low = 0;
    while (cfg_ready !== 1'b1 && low < 20) begin tick; low++; end
  endtask

  task automatic wait_init(output int n, output int rdy_hi);
    n = 0; rdy_hi = 0;
    while (init_done !== 1'b1 && n < 200) begin
      if (cfg_ready !== 1'b0) rdy_hi++;
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    int n, hi;
    rst = 1'b1;
    tick; tick;
    checks++;
    if ({a_all, b_all, axon_lm, init_done, cfg_ready, cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_outs got a=%h b=%h c=%b done=%b rdy=%b err=%b want all 0",
               a_all, b_all, axon_lm, init_done, cfg_ready, cfg_err);
    end
    rst = 1'b0;
    wait_init(n, hi);
    checks++;
    if (n != 16) begin errors++; $display("FAIL init_cycles got %0d want 16", n); end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL init_ready got %0d ready-high cycles want 0", hi); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_init got %b want 1", cfg_ready); end
    for (int i = 0; i < 4; i++) begin
      do_rd(8'(i), 8'(i), {8'(i), 8'(3 - i)});
      checks++;
      if ({a_all, b_all, axon_lm} !== '0) begin
        errors++;
        $display("FAIL cleared_rd%0d got a=%h b=%h c=%b want 0", i, a_all, b_all, axon_lm);
      end
    end
  endtask

  task automatic test_b_write;
    int low;
    cfg_write(2'd1, {8'd2, 8'd0}, 3'd2, 32'h0000_1234);
    wait_ready(low);
    checks++;
    if (low != 2) begin errors++; $display("FAIL b_wr1_ready_low got %0d want 2", low); end
    cfg_write(2'd1, {8'd2, 8'd0}, 3'd4, 32'hDEAD_BEEF);
    wait_ready(low);
    checks++;
    if (low != 2) begin errors++; $display("FAIL b_wr2_ready_low got %0d want 2", low); end
    do_rd(8'd0, 8'd2, 16'd0);
    checks++;
    if (th_mask !== 16'h1234) begin errors++; $display("FAIL b_th_mask got %h want 1234", th_mask); end
    checks++;
    if (spike_aer !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b_spike_aer got %h want deadbeef", spike_aer); end
    checks++;
    if ({nurn_type, rand_th, rst_pot} !== '0) begin
      errors++;
      $display("FAIL b_other_fields got type=%b rth=%b rpot=%h want 0", nurn_type, rand_th, rst_pot);
    end
    do_rd(8'd0, 8'd1, 16'd0);
    checks++;
    if (b_all !== '0) begin errors++; $display("FAIL b_neighbour got %h want 0", b_all); end
  endtask

  task automatic test_c_back_to_back;
    logic [15:0] waddr [4];
    logic        exp;
    waddr[0] = {8'd1, 8'd3}; waddr[1] = {8'd0, 8'd0}; waddr[2] = {8'd2, 8'd1}; waddr[3] = {8'd3, 8'd3};
    cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_field = 3'd6;
    for (int i = 0; i < 4; i++) begin
      cfg_addr = waddr[i];
      cfg_data = (i == 2) ? 32'hFFFF_FFF1 : 32'h1;
      tick;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL c_b2b_ready%0d got %b want 1", i, cfg_ready); end
    end
    cfg_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < 4; a++) begin
        exp = 1'b0;
        for (int k = 0; k < 4; k++) if (waddr[k] == {8'(n), 8'(a)}) exp = 1'b1;
        do_rd(8'd0, 8'd0, {8'(n), 8'(a)});
        checks++;
        if (axon_lm !== exp) begin errors++; $display("FAIL c_rd_%0d_%0d got %b want %b", n, a, axon_lm, exp); end
      end
    end
  endtask

  task automatic test_collision;
    int low;
    cfg_write(2'd0, {8'd1, 8'd0}, 3'd0, 32'h0000_005A);
    tick;
    addr_a = 8'd1; rd_a = 1'b1;
    tick;
    rd_a = 1'b0;
    checks++;
    if (ltp_win !== 8'h5A) begin errors++; $display("FAIL a_bypass_ltp got %h want 5a", ltp_win); end
    wait_ready(low);
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_addr = {8'd1, 8'd0}; cfg_field = 3'd1; cfg_data = 32'h33;
    addr_a = 8'd1; rd_a = 1'b1;
    tick;
    cfg_valid = 1'b0;
    checks++;
    if (ltd_win !== 8'h00) begin errors++; $display("FAIL a_accept_rd got %h want 00", ltd_win); end
    tick;
    checks++;
    if (ltd_win !== 8'h00) begin errors++; $display("FAIL a_rmwrd_rd got %h want 00", ltd_win); end
    tick;
    rd_a = 1'b0;
    checks++;
    if ({ltd_win, ltp_win} !== 16'h335A) begin
      errors++;
      $display("FAIL a_rmwwr_rd got %h want 335a", {ltd_win, ltp_win});
    end
    wait_ready(low);
    cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_addr = {8'd2, 8'd2}; cfg_data = 32'h1;
    addr_c = {8'd2, 8'd2}; rd_c = 1'b1;
    tick;
    cfg_valid = 1'b0; rd_c = 1'b0;
    checks++;
    if (axon_lm !== 1'b1) begin errors++; $display("FAIL c_bypass got %b want 1", axon_lm); end
  endtask

  task automatic test_errors;
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_idle got %b want 0", cfg_err); end
    cfg_write(2'd3, 16'd0, 3'd0, 32'hFFFF);
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b11) begin
      errors++;
      $display("FAIL err_sel3 got err=%b rdy=%b want err=1 rdy=1", cfg_err, cfg_ready);
    end
    cfg_write(2'd0, {8'd0, 8'd0}, 3'd5, 32'hFF);
    cfg_write(2'd1, {8'd4, 8'd0}, 3'd2, 32'h77);
    cfg_write(2'd2, {8'd0, 8'd4}, 3'd0, 32'h1);
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b11) begin
      errors++;
      $display("FAIL err_sticky got err=%b rdy=%b want err=1 rdy=1", cfg_err, cfg_ready);
    end
    do_rd(8'd0, 8'd0, {8'd1, 8'd0});
    checks++;
    if ({a_all, b_all, axon_lm} !== '0) begin
      errors++;
      $display("FAIL err_no_write got a=%h b=%h c=%b want 0", a_all, b_all, axon_lm);
    end
    do_rd(8'd5, 8'd6, {8'd0, 8'd7});
    checks++;
    if ({a_all, b_all, axon_lm} !== '0) begin
      errors++;
      $display("FAIL oob_read got a=%h b=%h c=%b want 0", a_all, b_all, axon_lm);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int n, hi;
    do_rd(8'd1, 8'd2, {8'd2, 8'd2});
    cfg_write(2'd0, {8'd1, 8'd0}, 3'd2, 32'hBEEF);
    rst = 1'b1;
    tick;
    checks++;
    if ({a_all, b_all, axon_lm, init_done, cfg_ready, cfg_err} !== '0) begin
      errors++;
      $display("FAIL rst_rmw_outs got a=%h b=%h c=%b done=%b rdy=%b err=%b want all 0",
               a_all, b_all, axon_lm, init_done, cfg_ready, cfg_err);
    end
    rst = 1'b0;
    wait_init(n, hi);
    checks++;
    if (n != 16 || hi != 0) begin
      errors++;
      $display("FAIL rst_rmw_reinit got %0d cycles %0d ready-high want 16 and 0", n, hi);
    end
    do_rd(8'd1, 8'd2, {8'd1, 8'd3});
    checks++;
    if ({a_all, b_all, axon_lm} !== '0) begin
      errors++;
      $display("FAIL rst_rmw_cleared got a=%h b=%h c=%b want 0", a_all, b_all, axon_lm);
    end
  endtask

  initial begin
    test_reset;
    test_b_write;
    test_c_back_to_back;
    test_collision;
    test_errors;
    test_reset_mid_rmw;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
